// File: rtl/chip8_draw_ctrl.sv
// CHIP-8 DXYN / 00E0 sequencer: fetches sprite bytes, XORs them into framebuffer rows
// one read-modify-write per row, and reports the VF collision flag with done.
module chip8_draw_ctrl #(
    parameter int ADDR_W   = 12,
    parameter bit WRAP_PIX = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_clear,
    input  logic [7:0]        cmd_x,
    input  logic [7:0]        cmd_y,
    input  logic [3:0]        cmd_n,
    input  logic [ADDR_W-1:0] cmd_i,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic [4:0]        fb_addr,
    output logic              fb_rd,
    input  logic [63:0]       fb_rdata,
    output logic              fb_we,
    output logic [63:0]       fb_wdata,
    output logic              busy,
    output logic              done,
    output logic              collision
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_CLR,
        ST_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [5:0]        x0_reg;
    logic [4:0]        y0_reg;
    logic [3:0]        n_reg;
    logic [ADDR_W-1:0] i_reg;
    logic [4:0]        row_reg, row_next;
    logic              coll_acc_reg, coll_acc_next;
    logic              coll_reg;

    logic [63:0]       sprite_word;
    logic [63:0]       mask;
    logic [4:0]        row_inc;
    logic [5:0]        next_y;
    logic              unused_bits;

    assign unused_bits = &{1'b0, cmd_x[7:6], cmd_y[7:5]};
    assign sprite_word = {mem_rdata, 56'd0};
    assign row_inc     = row_reg + 5'd1;
    assign next_y      = {1'b0, y0_reg} + {1'b0, row_inc};

    // Pixel gi of the shifted sprite comes from source pixel gi+x0; past the right
    // edge it is either dropped or taken modulo 64.
    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_mask
            logic [6:0] src_idx;
            assign src_idx = 7'(gi) + {1'b0, x0_reg};
            if (WRAP_PIX) begin : g_wrap
                assign mask[gi] = sprite_word[src_idx[5:0]];
            end else begin : g_clip
                assign mask[gi] = !src_idx[6] && sprite_word[src_idx[5:0]];
            end
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        row_next      = row_reg;
        coll_acc_next = coll_acc_reg;
        cmd_ready     = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        mem_rd        = 1'b0;
        mem_addr      = '0;
        fb_rd         = 1'b0;
        fb_we         = 1'b0;
        fb_addr       = '0;
        fb_wdata      = '0;
        unique case (state_reg)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    row_next      = '0;
                    coll_acc_next = 1'b0;
                    if (cmd_clear)
                        state_next = ST_CLR;
                    else if (cmd_n != 4'd0)
                        state_next = ST_RD;
                    else
                        state_next = ST_DONE;
                end
            end
            ST_RD: begin
                mem_rd     = 1'b1;
                mem_addr   = i_reg + ADDR_W'(row_reg);
                fb_rd      = 1'b1;
                fb_addr    = y0_reg + row_reg;
                state_next = ST_WR;
            end
            ST_WR: begin
                fb_we         = 1'b1;
                fb_addr       = y0_reg + row_reg;
                fb_wdata      = fb_rdata ^ mask;
                coll_acc_next = coll_acc_reg | (|(fb_rdata & mask));
                row_next      = row_inc;
                // Rows below the bottom edge are skipped entirely when clipping.
                if ((row_inc < {1'b0, n_reg}) && (WRAP_PIX || !next_y[5]))
                    state_next = ST_RD;
                else
                    state_next = ST_DONE;
            end
            ST_CLR: begin
                fb_we    = 1'b1;
                fb_addr  = row_reg;
                row_next = row_inc;
                if (row_reg == 5'd31)
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign collision = (state_reg == ST_DONE) ? coll_acc_reg : coll_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            row_reg      <= '0;
            coll_acc_reg <= 1'b0;
            coll_reg     <= 1'b0;
            x0_reg       <= '0;
            y0_reg       <= '0;
            n_reg        <= '0;
            i_reg        <= '0;
        end else begin
            state_reg    <= state_next;
            row_reg      <= row_next;
            coll_acc_reg <= coll_acc_next;
            if (state_reg == ST_DONE)
                coll_reg <= coll_acc_reg;
            if (state_reg == ST_IDLE && cmd_valid) begin
                x0_reg <= cmd_x[5:0];
                y0_reg <= cmd_y[4:0];
                n_reg  <= cmd_n;
                i_reg  <= cmd_i;
            end
        end
    end

endmodule

// File: tb/tb_chip8_draw_ctrl.sv
// Bench for chip8_draw_ctrl: one clipping and one wrapping instance, each backed by a
// behavioural memory/framebuffer, with reads, writes and completions scoreboarded.
`timescale 1ns/1ps
module tb_chip8_draw_ctrl;

    typedef struct { int dev; logic [11:0] addr; logic [4:0] row; } rd_t;
    typedef struct { int dev; logic [4:0] row; logic [63:0] data; } wr_t;
    typedef struct { int dev; int lat; logic coll; } done_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_clear;
    logic [7:0]  cmd_x, cmd_y;
    logic [3:0]  cmd_n;
    logic [11:0] cmd_i;

    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic [11:0] mem_addr  [2];
    logic        mem_rd    [2];
    logic [7:0]  mem_rdata [2];
    logic [4:0]  fb_addr   [2];
    logic        fb_rd     [2];
    logic [63:0] fb_rdata  [2];
    logic        fb_we     [2];
    logic [63:0] fb_wdata  [2];
    logic        busy      [2];
    logic        done      [2];
    logic        collision [2];

    logic [7:0]  mem    [4096];
    logic [63:0] fb_ram [2][32];
    logic [63:0] ref_fb [2][32];

    rd_t   exp_rd[$];
    wr_t   exp_wr[$];
    done_t exp_done[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   t0       [2];
    logic last_coll[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    chip8_draw_ctrl #(.ADDR_W(12), .WRAP_PIX(1'b0)) dut_clip (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_clear(cmd_clear),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_n(cmd_n), .cmd_i(cmd_i),
        .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]), .mem_rdata(mem_rdata[0]),
        .fb_addr(fb_addr[0]), .fb_rd(fb_rd[0]), .fb_rdata(fb_rdata[0]),
        .fb_we(fb_we[0]), .fb_wdata(fb_wdata[0]),
        .busy(busy[0]), .done(done[0]), .collision(collision[0])
    );

    chip8_draw_ctrl #(.ADDR_W(12), .WRAP_PIX(1'b1)) dut_wrap (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_clear(cmd_clear),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_n(cmd_n), .cmd_i(cmd_i),
        .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]), .mem_rdata(mem_rdata[1]),
        .fb_addr(fb_addr[1]), .fb_rd(fb_rd[1]), .fb_rdata(fb_rdata[1]),
        .fb_we(fb_we[1]), .fb_wdata(fb_wdata[1]),
        .busy(busy[1]), .done(done[1]), .collision(collision[1])
    );

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_rd[d]) mem_rdata[d] <= mem[mem_addr[d]];
            if (fb_rd[d])  fb_rdata[d]  <= fb_ram[d][fb_addr[d]];
            if (fb_we[d])  fb_ram[d][fb_addr[d]] <= fb_wdata[d];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: expected reads, writes and completion for one command.
    task automatic expect_cmd(input int d, input bit clr, input logic [7:0] x,
                              input logic [7:0] y, input logic [3:0] n, input logic [11:0] i);
        int          x0, y0, rows, row, col;
        logic [11:0] addr;
        logic [7:0]  b;
        logic [63:0] mask, old;
        logic        coll;
        rows = 0;
        coll = 1'b0;
        if (clr) begin
            for (int r = 0; r < 32; r++) begin
                exp_wr.push_back('{d, 5'(r), 64'd0});
                ref_fb[d][r] = 64'd0;
            end
            exp_done.push_back('{d, 33, 1'b0});
            return;
        end
        x0 = int'(x) % 64;
        y0 = int'(y) % 32;
        for (int r = 0; r < int'(n); r++) begin
            row = y0 + r;
            if (d == 0 && row >= 32) break;
            row  = row % 32;
            addr = i + 12'(r);
            b    = mem[addr];
            mask = '0;
            for (int k = 0; k < 8; k++) begin
                col = x0 + k;
                if (col >= 64) begin
                    if (d == 0) continue;
                    col -= 64;
                end
                mask[63-col] = b[7-k];
            end
            old  = ref_fb[d][row];
            coll = coll | (|(old & mask));
            ref_fb[d][row] = old ^ mask;
            exp_rd.push_back('{d, addr, 5'(row)});
            exp_wr.push_back('{d, 5'(row), old ^ mask});
            rows++;
        end
        exp_done.push_back('{d, 2 * rows + 1, coll});
    endtask

    task automatic mon(input int d);
        rd_t   er;
        wr_t   ew;
        done_t ed;
        if (cmd_valid[d] && cmd_ready[d]) t0[d] = cyc;
        if (mem_rd[d] || fb_rd[d] || fb_we[d])
            check("strobe_excl", 64'(fb_we[d] & (mem_rd[d] | fb_rd[d])), 64'd0);
        if (mem_rd[d] || fb_rd[d]) begin
            check("rd_pair", 64'(mem_rd[d]), 64'(fb_rd[d]));
            if (exp_rd.size() == 0 || exp_rd[0].dev != d) begin
                check("rd_unexpected", 64'(1), 64'(0));
            end else begin
                er = exp_rd.pop_front();
                check("rd_addr", 64'(mem_addr[d]), 64'(er.addr));
                check("rd_row", 64'(fb_addr[d]), 64'(er.row));
            end
        end
        if (fb_we[d]) begin
            if (exp_wr.size() == 0 || exp_wr[0].dev != d) begin
                check("wr_unexpected", 64'(fb_addr[d]) + 64'h100, 64'(0));
            end else begin
                ew = exp_wr.pop_front();
                check("wr_row", 64'(fb_addr[d]), 64'(ew.row));
                check("wr_data", fb_wdata[d], ew.data);
            end
        end
        if (done[d]) begin
            if (exp_done.size() == 0 || exp_done[0].dev != d) begin
                check("done_unexpected", 64'(1), 64'(0));
            end else begin
                ed = exp_done.pop_front();
                check("done_lat", 64'(cyc - t0[d]), 64'(ed.lat));
                check("collision", 64'(collision[d]), 64'(ed.coll));
                last_coll[d] = ed.coll;
                $display("dev%0d command done: latency %0d collision %0d", d, cyc - t0[d], collision[d]);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) mon(d);
    end

    task automatic send(input int d, input bit clr, input logic [7:0] x, input logic [7:0] y,
                        input logic [3:0] n, input logic [11:0] i);
        int guard;
        expect_cmd(d, clr, x, y, n, i);
        cmd_clear    = clr;
        cmd_x        = x;
        cmd_y        = y;
        cmd_n        = n;
        cmd_i        = i;
        cmd_valid[d] = 1'b1;
        guard = 0;
        while (!cmd_ready[d] && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!cmd_ready[d]) check("accept_timeout", 64'(1), 64'(0));
        @(posedge clk); #1;
        cmd_valid[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int guard;
        guard = 0;
        while ((exp_done.size() != 0 || exp_wr.size() != 0 || exp_rd.size() != 0) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) begin
            check("drain_timeout", 64'(1), 64'(0));
            exp_rd.delete();
            exp_wr.delete();
            exp_done.delete();
        end
        @(posedge clk); #1;
        check("idle_busy", 64'(busy[d]), 64'd0);
        check("coll_hold", 64'(collision[d]), 64'(last_coll[d]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int seen, guard;
        reset        = 1'b1;
        cmd_valid[0] = 1'b0;
        cmd_valid[1] = 1'b0;
        cmd_clear    = 1'b0;
        cmd_x        = '0;
        cmd_y        = '0;
        cmd_n        = '0;
        cmd_i        = '0;
        last_coll[0] = 1'b0;
        last_coll[1] = 1'b0;
        for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
        mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
        mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0;
        for (int a = 0; a < 5; a++) mem[12'h100 + 12'(a)] = 8'hFF;
        mem[12'hFFF] = 8'h81;
        mem[12'h000] = 8'h3C;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",    64'(cmd_ready[0]), 64'd1);
        check("rst_busy",     64'(busy[0]),      64'd0);
        check("rst_done",     64'(done[0]),      64'd0);
        check("rst_coll",     64'(collision[0]), 64'd0);
        check("rst_strobes",  64'({mem_rd[0], fb_rd[0], fb_we[0]}), 64'd0);
        check("rst_mem_addr", 64'(mem_addr[0]),  64'd0);
        check("rst_fb_addr",  64'(fb_addr[0]),   64'd0);
        check("rst_fb_wdata", fb_wdata[0],       64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Clear both framebuffers, then digit "0" drawn twice (second erases it).
        send(0, 1'b1, 8'd0, 8'd0, 4'd0, 12'h000); wait_idle(0);
        send(1, 1'b1, 8'd0, 8'd0, 4'd0, 12'h000); wait_idle(1);
        send(0, 1'b0, 8'd0, 8'd0, 4'd5, 12'h050); wait_idle(0);
        send(0, 1'b0, 8'd0, 8'd0, 4'd5, 12'h050); wait_idle(0);

        // Corner sprite: clipped on one instance, wrapped on the other.
        send(0, 1'b0, 8'd60, 8'd30, 4'd5, 12'h100); wait_idle(0);
        send(1, 1'b0, 8'd60, 8'd30, 4'd5, 12'h100); wait_idle(1);

        // Coordinate masking, zero-height sprite, address wrap of I.
        send(0, 1'b0, 8'h45, 8'h22, 4'd1, 12'h060); wait_idle(0);
        send(0, 1'b0, 8'd7, 8'd9, 4'd0, 12'h070);   wait_idle(0);
        send(0, 1'b0, 8'd20, 8'd10, 4'd2, 12'hFFF); wait_idle(0);

        // Reset in the write cycle of row 2 aborts the draw.
        send(0, 1'b0, 8'd3, 8'd0, 4'd5, 12'h050);
        seen  = 0;
        guard = 0;
        while (seen < 3 && guard < 50) begin
            if (fb_we[0]) seen++;
            if (seen < 3) begin
                @(posedge clk); #1;
            end
            guard++;
        end
        check("abort_reach_wr2", 64'(seen), 64'd3);
        reset = 1'b1;
        @(posedge clk); #1;
        exp_rd.delete();
        exp_wr.delete();
        exp_done.delete();
        check("abort_no_we",  64'(fb_we[0]),     64'd0);
        check("abort_done",   64'(done[0]),      64'd0);
        check("abort_ready",  64'(cmd_ready[0]), 64'd1);
        check("abort_busy",   64'(busy[0]),      64'd0);
        reset        = 1'b0;
        last_coll[0] = 1'b0;
        last_coll[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        send(0, 1'b1, 8'd0, 8'd0, 4'd0, 12'h000);  wait_idle(0);
        send(0, 1'b0, 8'd10, 8'd4, 4'd5, 12'h050); wait_idle(0);

        for (int k = 0; k < 12; k++) begin
            int d;
            d = int'($urandom_range(0, 1));
            send(d, 1'b0, 8'($urandom), 8'($urandom), 4'($urandom), 12'($urandom));
            wait_idle(d);
        end

        check("leftover", 64'(exp_rd.size() + exp_wr.size() + exp_done.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
